rs_kes_ibm: RTL
===============

Name: rs_kes_ibm

Overview:
Key-equation solver for the DVB-T RS(204,188) decoder, t=8. Sits directly downstream of the syndrome stage.
- Accepts S1..S16 with a valid strobe.
- Runs a serial inversionless Berlekamp-Massey (iBM) algorithm, one iteration per clock.
- Outputs the error-locator Λ(x), error-evaluator Ω(x), locator degree and an uncorrectable flag to the Chien/Forney stage.

Parameters:
PRIM_POLY, 9'h11D, GF(2^8) field polynomial x^8+x^4+x^3+x^2+1; must match the syndrome stage.
SYM_W, 8, symbol width; fixed at 8 for DVB-T.

Ports:
Clk  input  1  system clock, all logic on rising edge.
Reset  input  1  synchronous active-low reset: 0 at a rising Clk edge resets the block.
Synd_Valid  input  1  one-cycle strobe; S1..S16 valid.
S1..S16  input  8 each  syndromes, S_j = r(α^j).
Kes_Busy  output  1  high from accept edge until Kes_Valid edge.
Kes_Valid  output  1  one-cycle pulse; result outputs valid.
Lambda  output  72  Λ0..Λ8, Λ_i at [8i+7:8i].
Omega  output  64  Ω0..Ω7, Ω_i at [8i+7:8i].
Deg_L  output  5  final LFSR length L (0..16).
Uncorrectable  output  1  L>8 at end of the run; valid with Kes_Valid.

Behaviour:
Reset values: Lambda=0, Omega=0, Deg_L=0, Kes_Valid=0, Kes_Busy=0, Uncorrectable=0, FSM=IDLE. Reset low mid-run aborts the run: no Kes_Valid pulse, and all state returns to reset values.

FSM states: IDLE, ITER, OMEGA.
- IDLE:
  - Synd_Valid=1 at edge N: latch S1..S16; init Λ=1, B=1, γ=1, L=0, r=0; Kes_Busy<=1; go to ITER.
  - Synd_Valid=0: stay in IDLE.
- ITER, edges N+1..N+16 (r=0..15):
  - δ = Σ_{i=0..8} Λ_i·S_{r+1-i}, with S_j=0 for j<1.
  - Λ <= γΛ + δ·x·B, truncated to degree 8.
  - If δ≠0 and 2L≤r: B<=Λ_old, γ<=δ, L<=r+1-L.
  - Else: B<=x·B (truncated to degree 8).
  - r=15 → go to OMEGA.
- OMEGA, edges N+17..N+24, i=0..7: Ω_i = Σ_{j=0..i} Λ_j·S_{i-j+1}. The 9-multiplier datapath is reused, one coefficient per cycle.
- Edge N+24: Kes_Valid<=1 for one cycle; Kes_Busy<=0; go to IDLE. Fixed latency is 24 cycles from accept edge to Kes_Valid.

Output and handshake rules:
- Lambda, Omega, Deg_L and Uncorrectable update only when the run completes and hold until the next completion. Internal working registers are separate from the output registers.
- Synd_Valid while Kes_Busy=1 is ignored; no queueing.
- Synd_Valid in the same cycle as Kes_Valid=1 is accepted, because the FSM is already in IDLE. Back-to-back period is 25 cycles.

Arithmetic and flag rules:
- GF addition is XOR. Multiply is polynomial multiply mod PRIM_POLY.
- Λ and Ω share the common nonzero iBM scale factor. Downstream Forney is scale-invariant, so no normalisation is done.
- Uncorrectable is set sticky during the run when L exceeds 8, and cleared at accept. L never decreases; a truncated Λ is irrelevant once flagged.

Optional Feature:
Macro KES_ZERO_BYPASS_EN.
- Defined: at accept, if all S1..S16 are 0, skip ITER/OMEGA. On the next edge (N+1): Lambda=72'h01, Omega=0, Deg_L=0, Uncorrectable=0, Kes_Valid pulse.
- Undefined: zero syndromes take the full 24-cycle path with identical final values.
- Downstream stages must tolerate both latencies, since they key only on Kes_Valid.

Decomposition:
- Package rs_pkg holds:
  - RS_T=8, RS_NSYN=16, GF_PRIM_POLY=9'h11D, SYM_W.
  - FSM state typedef/localparams.
  - Lambda/Omega packing width constants, shared with the Chien/Forney stage.
- One sub-module: gf256_mul, a combinational GF(2^8) multiplier parameterised by PRIM_POLY. It is instantiated 9× for δ/Ω, plus 2×9 for the Λ update.

Test Plan:
- All-zero syndromes, reset released → Kes_Valid exactly 24 cycles after accept (1 with bypass); Lambda=72'h01, Omega=0, Deg_L=0, Uncorrectable=0.
- Single error e=1 at X=1 (all S_j=8'h01) → Lambda=72'h0101 (1+x), Omega=64'h01, Deg_L=1, Uncorrectable=0.
- Golden vectors, MATLAB syndromes for 1..8 random errors → Lambda/Omega/Deg_L match MATLAB iBM bit-exactly.
- Golden vectors for 9 errors → Uncorrectable=1, Deg_L≥9.
- Synd_Valid pulsed at accept+5 with different syndromes → ignored; first result unchanged, one Kes_Valid only. A second Synd_Valid on the Kes_Valid cycle → accepted, result 24 cycles later.
- Reset low at accept+10 for one edge → Kes_Busy=0, no Kes_Valid, outputs zero. A fresh run then completes correctly.

Source files
------------

// File: rtl/rs_pkg.sv
// rs_pkg: shared constants and types for the RS(204,188) t=8 decoder slice.
// Holds code parameters, the GF(2^8) field polynomial, the key-equation
// solver FSM state type, and the Lambda/Omega packing widths that the
// Chien/Forney stage also uses.
package rs_pkg;

    localparam int RS_T     = 8;
    localparam int RS_NSYN  = 16;
    localparam int SYM_W    = 8;

    localparam logic [8:0] GF_PRIM_POLY = 9'h11D;

    // Lambda carries T+1 coefficients, Omega carries T coefficients.
    localparam int LAMBDA_NC = RS_T + 1;
    localparam int OMEGA_NC  = RS_T;
    localparam int LAMBDA_W  = LAMBDA_NC * SYM_W;
    localparam int OMEGA_W   = OMEGA_NC * SYM_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_OMEGA = 2'd2
    } kes_state_t;

endpackage

// File: rtl/gf256_mul.sv
// gf256_mul: combinational GF(2^8) multiplier, p = a*b mod PRIM_POLY.
// Ports:
//   a, b  input  8   operands
//   p     output 8   product
module gf256_mul
    import rs_pkg::*;
#(
    parameter logic [8:0] PRIM_POLY = GF_PRIM_POLY
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] acc;
    logic [7:0] sh;

    // Shift-and-add: sh walks through a*x^i reduced mod PRIM_POLY.
    always_comb begin
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? PRIM_POLY[7:0] : 8'h00);
        end
        p = acc;
    end

endmodule

// File: rtl/rs_kes_ibm.sv
// rs_kes_ibm: serial inversionless Berlekamp-Massey key-equation solver for
// the DVB-T RS(204,188) decoder (t=8). One iBM iteration per clock, then
// Omega coefficients one per clock on the same 9-multiplier datapath.
// Fixed latency 24 cycles from accept edge to Kes_Valid.
// Optional macro KES_ZERO_BYPASS_EN: all-zero syndromes complete on the
// edge after accept instead of running the full iteration.
// Ports:
//   Clk            input   1   system clock, rising edge
//   Reset          input   1   synchronous active-low reset
//   Synd_Valid     input   1   one-cycle strobe, S1..S16 valid
//   S1..S16        input   8   syndromes S_j = r(alpha^j)
//   Kes_Busy       output  1   high from accept edge until Kes_Valid edge
//   Kes_Valid      output  1   one-cycle pulse, results valid
//   Lambda         output  72  error locator, Lambda_i at [8i+7:8i]
//   Omega          output  64  error evaluator, Omega_i at [8i+7:8i]
//   Deg_L          output  5   final LFSR length L
//   Uncorrectable  output  1   L exceeded 8 during the run
module rs_kes_ibm
    import rs_pkg::*;
#(
    parameter logic [8:0] PRIM_POLY = GF_PRIM_POLY,
    parameter int         SYM_W     = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Synd_Valid,
    input  logic [SYM_W-1:0]     S1,
    input  logic [SYM_W-1:0]     S2,
    input  logic [SYM_W-1:0]     S3,
    input  logic [SYM_W-1:0]     S4,
    input  logic [SYM_W-1:0]     S5,
    input  logic [SYM_W-1:0]     S6,
    input  logic [SYM_W-1:0]     S7,
    input  logic [SYM_W-1:0]     S8,
    input  logic [SYM_W-1:0]     S9,
    input  logic [SYM_W-1:0]     S10,
    input  logic [SYM_W-1:0]     S11,
    input  logic [SYM_W-1:0]     S12,
    input  logic [SYM_W-1:0]     S13,
    input  logic [SYM_W-1:0]     S14,
    input  logic [SYM_W-1:0]     S15,
    input  logic [SYM_W-1:0]     S16,
    output logic                 Kes_Busy,
    output logic                 Kes_Valid,
    output logic [LAMBDA_W-1:0]  Lambda,
    output logic [OMEGA_W-1:0]   Omega,
    output logic [4:0]           Deg_L,
    output logic                 Uncorrectable
);

`ifdef KES_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    kes_state_t state;

    logic [SYM_W-1:0] s_in  [RS_NSYN];
    logic [SYM_W-1:0] syn   [RS_NSYN];
    logic [SYM_W-1:0] lam   [LAMBDA_NC];
    logic [SYM_W-1:0] bb    [LAMBDA_NC];
    logic [SYM_W-1:0] gam;
    logic [4:0]       len;
    logic [3:0]       rr;
    logic [2:0]       oc;
    logic             unc_run;
    logic             zbyp;
    // Omega coefficients shift in from the top; Omega7 joins at completion.
    logic [OMEGA_W-SYM_W-1:0] om_sr;

    logic [3:0]       idx;
    logic [SYM_W-1:0] s_sel   [LAMBDA_NC];
    logic [SYM_W-1:0] prod_s  [LAMBDA_NC];
    logic [SYM_W-1:0] prod_g  [LAMBDA_NC];
    logic [SYM_W-1:0] prod_d  [LAMBDA_NC];
    logic [SYM_W-1:0] db_in   [LAMBDA_NC];
    logic [SYM_W-1:0] lam_nxt [LAMBDA_NC];
    logic [SYM_W-1:0] sum;
    logic             swap;
    logic [4:0]       len_new;
    logic             syn_zero;

    assign s_in[0]  = S1;   assign s_in[1]  = S2;
    assign s_in[2]  = S3;   assign s_in[3]  = S4;
    assign s_in[4]  = S5;   assign s_in[5]  = S6;
    assign s_in[6]  = S7;   assign s_in[7]  = S8;
    assign s_in[8]  = S9;   assign s_in[9]  = S10;
    assign s_in[10] = S11;  assign s_in[11] = S12;
    assign s_in[12] = S13;  assign s_in[13] = S14;
    assign s_in[14] = S15;  assign s_in[15] = S16;

    assign syn_zero = ~|{S1, S2, S3, S4, S5, S6, S7, S8,
                         S9, S10, S11, S12, S13, S14, S15, S16};

    // The same convolution sum serves delta (index r) and Omega_i (index i).
    assign idx = (state == ST_OMEGA) ? {1'b0, oc} : rr;

    always_comb begin
        for (int unsigned i = 0; i < LAMBDA_NC; i++) begin
            s_sel[i] = (32'(idx) >= i) ? syn[idx - 4'(i)] : '0;
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < LAMBDA_NC; i++) begin
            sum = sum ^ prod_s[i];
        end
    end

    always_comb begin
        db_in[0] = '0;
        for (int unsigned i = 1; i < LAMBDA_NC; i++) begin
            db_in[i] = bb[i-1];
        end
        for (int unsigned i = 0; i < LAMBDA_NC; i++) begin
            lam_nxt[i] = prod_g[i] ^ prod_d[i];
        end
    end

    assign swap    = (sum != '0) && ({len, 1'b0} <= {2'b00, rr});
    assign len_new = {1'b0, rr} + 5'd1 - len;

    for (genvar g = 0; g < LAMBDA_NC; g++) begin : g_mul
        gf256_mul #(.PRIM_POLY(PRIM_POLY)) u_syn (
            .a(lam[g]), .b(s_sel[g]), .p(prod_s[g]));
        gf256_mul #(.PRIM_POLY(PRIM_POLY)) u_gam (
            .a(gam),    .b(lam[g]),   .p(prod_g[g]));
        gf256_mul #(.PRIM_POLY(PRIM_POLY)) u_del (
            .a(sum),    .b(db_in[g]), .p(prod_d[g]));
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= ST_IDLE;
            Kes_Busy      <= 1'b0;
            Kes_Valid     <= 1'b0;
            Lambda        <= '0;
            Omega         <= '0;
            Deg_L         <= '0;
            Uncorrectable <= 1'b0;
            for (int unsigned k = 0; k < RS_NSYN; k++) begin
                syn[k] <= '0;
            end
            for (int unsigned i = 0; i < LAMBDA_NC; i++) begin
                lam[i] <= '0;
                bb[i]  <= '0;
            end
            gam     <= '0;
            len     <= '0;
            rr      <= '0;
            oc      <= '0;
            unc_run <= 1'b0;
            zbyp    <= 1'b0;
            om_sr   <= '0;
        end else begin
            Kes_Valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Synd_Valid) begin
                        for (int unsigned k = 0; k < RS_NSYN; k++) begin
                            syn[k] <= s_in[k];
                        end
                        for (int unsigned i = 0; i < LAMBDA_NC; i++) begin
                            lam[i] <= (i == 0) ? 8'h01 : 8'h00;
                            bb[i]  <= (i == 0) ? 8'h01 : 8'h00;
                        end
                        gam      <= 8'h01;
                        len      <= '0;
                        rr       <= '0;
                        oc       <= '0;
                        unc_run  <= 1'b0;
                        zbyp     <= ZERO_BYPASS && syn_zero;
                        Kes_Busy <= 1'b1;
                        state    <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    if (zbyp) begin
                        Lambda        <= {{(LAMBDA_W-SYM_W){1'b0}}, 8'h01};
                        Omega         <= '0;
                        Deg_L         <= '0;
                        Uncorrectable <= 1'b0;
                        Kes_Valid     <= 1'b1;
                        Kes_Busy      <= 1'b0;
                        zbyp          <= 1'b0;
                        state         <= ST_IDLE;
                    end else begin
                        for (int unsigned i = 0; i < LAMBDA_NC; i++) begin
                            lam[i] <= lam_nxt[i];
                        end
                        if (swap) begin
                            for (int unsigned i = 0; i < LAMBDA_NC; i++) begin
                                bb[i] <= lam[i];
                            end
                            gam <= sum;
                            len <= len_new;
                            if (len_new > 5'd8) begin
                                unc_run <= 1'b1;
                            end
                        end else begin
                            bb[0] <= '0;
                            for (int unsigned i = 1; i < LAMBDA_NC; i++) begin
                                bb[i] <= bb[i-1];
                            end
                        end
                        rr <= rr + 4'd1;
                        if (rr == 4'd15) begin
                            state <= ST_OMEGA;
                        end
                    end
                end
                ST_OMEGA: begin
                    om_sr <= {sum, om_sr[OMEGA_W-SYM_W-1:SYM_W]};
                    oc    <= oc + 3'd1;
                    if (oc == 3'd7) begin
                        for (int unsigned i = 0; i < LAMBDA_NC; i++) begin
                            Lambda[8*i +: 8] <= lam[i];
                        end
                        Omega         <= {sum, om_sr};
                        Deg_L         <= len;
                        Uncorrectable <= unc_run;
                        Kes_Valid     <= 1'b1;
                        Kes_Busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
